// File: rtl/mixer_pkg.sv
// Shared types and helpers for the time-multiplexed channel mixer.
// Holds the FSM state type, accumulator sizing and the saturating narrow.
package mixer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    FINAL,
    OUTPUT
  } state_t;

  localparam int SAT_MAX_W = 64;

  typedef struct packed {
    logic                        clip;
    logic signed [SAT_MAX_W-1:0] value;
  } sat_t;

  // Sign, full product width, and log2(NUM_CH) bits of growth for the sum.
  function automatic int acc_width(input int sample_w, input int vol_w, input int num_ch);
    return sample_w + vol_w + 1 + $clog2(num_ch);
  endfunction

  function automatic sat_t sat_narrow(input logic signed [SAT_MAX_W-1:0] val, input int width);
    logic signed [SAT_MAX_W-1:0] hi;
    logic signed [SAT_MAX_W-1:0] lo;
    sat_t                        res;
    hi = (SAT_MAX_W'(1) << (width - 1)) - SAT_MAX_W'(1);
    lo = ~hi;
    res.clip = (val > hi) || (val < lo);
    if (val > hi)
      res.value = hi;
    else if (val < lo)
      res.value = lo;
    else
      res.value = val;
    return res;
  endfunction

endpackage

// File: rtl/mixer_saturator.sv
// Combinational attenuation shift and saturation of the mixer accumulator.
// Floor rounding comes from the arithmetic right shift.
module mixer_saturator
  import mixer_pkg::*;
#(
  parameter int IN_W     = 27,
  parameter int SHIFT    = 9,
  parameter int SAMPLE_W = 16
) (
  input  logic signed [IN_W-1:0]     value,
  output logic signed [SAMPLE_W-1:0] result,
  output logic                       clip
);

  logic signed [IN_W-1:0]      shifted;
  logic signed [SAT_MAX_W-1:0] wide;
  sat_t                        sat;
  logic                        sat_unused;

  assign shifted = value >>> SHIFT;
  assign wide    = {{(SAT_MAX_W-IN_W){shifted[IN_W-1]}}, shifted};

  always_comb begin
    sat    = sat_narrow(wide, SAMPLE_W);
    result = sat.value[SAMPLE_W-1:0];
    clip   = sat.clip;
  end

  // Clamped value always fits in SAMPLE_W bits; upper bits are redundant sign.
  assign sat_unused = ^sat.value[SAT_MAX_W-1:SAMPLE_W];

endmodule

// File: rtl/channel_mixer.sv
// N-channel audio mixer: one multiply-accumulate per cycle over a latched frame,
// then attenuate, saturate and hold the result on a valid/ready output.
module channel_mixer
  import mixer_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int SAMPLE_W    = 16,
  parameter int VOL_W       = 8,
  parameter int ATTEN_SHIFT = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_CH*SAMPLE_W-1:0]   samples,
  input  logic [NUM_CH*VOL_W-1:0]      volumes,
  input  logic [NUM_CH-1:0]            mute,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [SAMPLE_W-1:0]   out_sample,
  output logic                         clip
);

  localparam int ACC_W  = acc_width(SAMPLE_W, VOL_W, NUM_CH);
  localparam int PROD_W = SAMPLE_W + VOL_W + 1;
  localparam int IDX_W  = $clog2(NUM_CH);
  localparam int SHIFT  = VOL_W - 1 + ATTEN_SHIFT;

  state_t                      state;
  state_t                      state_next;
  logic                        accept;
  logic                        last;
  logic [NUM_CH*SAMPLE_W-1:0]  frame_samples;
  logic [NUM_CH*VOL_W-1:0]     frame_volumes;
  logic [NUM_CH-1:0]           frame_mute;
  logic [IDX_W-1:0]            idx;
  logic signed [ACC_W-1:0]     acc;
  logic signed [SAMPLE_W-1:0]  cur_sample;
  logic [VOL_W-1:0]            cur_vol;
  logic signed [PROD_W-1:0]    prod;
  logic signed [ACC_W-1:0]     term;
  logic signed [SAMPLE_W-1:0]  sat_sample;
  logic                        sat_clip;

  assign in_ready  = (state == IDLE) && !reset;
  assign out_valid = (state == OUTPUT);
  assign accept    = in_valid && in_ready;
  assign last      = (idx == IDX_W'(NUM_CH - 1));

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ACCUM;
      ACCUM:   if (last) state_next = FINAL;
      FINAL:   state_next = OUTPUT;
      OUTPUT:  if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Frame capture: buses are sampled only on the accept edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      frame_samples <= samples;
      frame_volumes <= volumes;
      frame_mute    <= mute;
    end
  end

  // MAC: signed sample times zero-extended volume, sign-extended into acc.
  always_comb begin
    cur_sample = frame_samples[idx*SAMPLE_W +: SAMPLE_W];
    cur_vol    = frame_volumes[idx*VOL_W +: VOL_W];
    prod       = cur_sample * $signed({1'b0, cur_vol});
    term       = frame_mute[idx] ? '0 : {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= '0;
      idx        <= '0;
      out_sample <= '0;
      clip       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc <= '0;
            idx <= '0;
          end
        end
        ACCUM: begin
          acc <= acc + term;
          idx <= last ? '0 : idx + 1'b1;
        end
        FINAL: begin
          out_sample <= sat_sample;
          clip       <= sat_clip;
        end
        default: ;
      endcase
    end
  end

  mixer_saturator #(
    .IN_W     (ACC_W),
    .SHIFT    (SHIFT),
    .SAMPLE_W (SAMPLE_W)
  ) u_sat (
    .value  (acc),
    .result (sat_sample),
    .clip   (sat_clip)
  );

endmodule

// File: tb/tb_channel_mixer.sv
// Scoreboard bench for channel_mixer at default parameters.
module tb_channel_mixer;

  localparam int NUM_CH      = 4;
  localparam int SAMPLE_W    = 16;
  localparam int VOL_W       = 8;
  localparam int ATTEN_SHIFT = 2;

  logic                         clk;
  logic                         reset;
  logic                         in_valid;
  logic                         in_ready;
  logic [NUM_CH*SAMPLE_W-1:0]   samples;
  logic [NUM_CH*VOL_W-1:0]      volumes;
  logic [NUM_CH-1:0]            mute;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [SAMPLE_W-1:0]   out_sample;
  logic                         clip;

  typedef struct {
    logic signed [SAMPLE_W-1:0] s;
    logic                       c;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  channel_mixer #(
    .NUM_CH      (NUM_CH),
    .SAMPLE_W    (SAMPLE_W),
    .VOL_W       (VOL_W),
    .ATTEN_SHIFT (ATTEN_SHIFT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .samples    (samples),
    .volumes    (volumes),
    .mute       (mute),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sample (out_sample),
    .clip       (clip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "global timeout");
  end

  function automatic exp_t model(input logic [NUM_CH*SAMPLE_W-1:0] s,
                                 input logic [NUM_CH*VOL_W-1:0] v,
                                 input logic [NUM_CH-1:0] m);
    longint acc;
    longint sh;
    exp_t   e;
    acc = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      logic signed [SAMPLE_W-1:0] sk;
      logic [VOL_W-1:0]           vk;
      sk = s[k*SAMPLE_W +: SAMPLE_W];
      vk = v[k*VOL_W +: VOL_W];
      if (!m[k]) acc += longint'(sk) * longint'({56'd0, vk});
    end
    sh = acc >>> (VOL_W - 1 + ATTEN_SHIFT);
    if (sh > 32767) begin
      e.s = 16'sh7fff; e.c = 1'b1;
    end else if (sh < -32768) begin
      e.s = -16'sh8000; e.c = 1'b1;
    end else begin
      e.s = SAMPLE_W'(sh); e.c = 1'b0;
    end
    return e;
  endfunction

  function automatic logic [NUM_CH*SAMPLE_W-1:0] pack_s(input logic signed [15:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic logic [NUM_CH*VOL_W-1:0] pack_v(input logic [7:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic send_frame(input logic [NUM_CH*SAMPLE_W-1:0] s,
                            input logic [NUM_CH*VOL_W-1:0] v,
                            input logic [NUM_CH-1:0] m);
    int t;
    t = 0;
    @(negedge clk);
    samples  = s;
    volumes  = v;
    mute     = m;
    in_valid = 1'b1;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout in_ready=%0b required 1", in_ready);
    end else begin
      sb.push_back(model(s, v, m));
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_output(output int lat);
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL output_timeout out_valid=%0b required 1", out_valid);
    end
  endtask

  task automatic consume(input string name);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty got sample=%0d", name, out_sample);
    end else begin
      e = sb.pop_front();
      if (out_sample !== e.s) begin
        errors++;
        $display("FAIL %s out_sample got %0d expected %0d", name, out_sample, e.s);
      end
      checks++;
      if (clip !== e.c) begin
        errors++;
        $display("FAIL %s clip got %0b expected %0b", name, clip, e.c);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s after_handshake in_ready=%0b out_valid=%0b expected 1/0", name, in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    samples = '0; volumes = '0; mute = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_sample !== 16'sd0 || clip !== 1'b0) begin
      errors++;
      $display("FAIL reset_state in_ready=%0b out_valid=%0b out_sample=%0d clip=%0b expected 0/0/0/0",
               in_ready, out_valid, out_sample, clip);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release in_ready=%0b expected 1", in_ready);
    end
  endtask

  task automatic test_unity();
    int lat;
    send_frame(pack_s(16'sd1000, 16'sd2000, 16'sd3000, 16'sd4000), pack_v(128, 128, 128, 128), 4'b0000);
    sb[sb.size()-1] = '{s: 16'sd2500, c: 1'b0};
    wait_output(lat);
    checks++;
    if (lat != NUM_CH + 1) begin
      errors++;
      $display("FAIL unity_latency got %0d expected %0d", lat, NUM_CH + 1);
    end
    consume("unity");
  endtask

  task automatic test_saturation();
    int lat;
    send_frame(pack_s(16'sh7fff, 16'sh7fff, 16'sh7fff, 16'sh7fff), pack_v(255, 255, 255, 255), 4'b0000);
    sb[sb.size()-1] = '{s: 16'sh7fff, c: 1'b1};
    wait_output(lat);
    consume("pos_sat");
    send_frame(pack_s(-16'sh8000, -16'sh8000, -16'sh8000, -16'sh8000), pack_v(255, 255, 255, 255), 4'b0000);
    sb[sb.size()-1] = '{s: -16'sh8000, c: 1'b1};
    wait_output(lat);
    consume("neg_sat");
  endtask

  task automatic test_mute_floor();
    int lat;
    send_frame(pack_s(16'sd4000, 16'sd4000, 16'sd4000, 16'sd4000), pack_v(128, 128, 128, 128), 4'b0101);
    sb[sb.size()-1] = '{s: 16'sd2000, c: 1'b0};
    wait_output(lat);
    consume("mute");
    send_frame(pack_s(-16'sd1, 16'sd0, 16'sd0, 16'sd0), pack_v(128, 128, 128, 128), 4'b0000);
    sb[sb.size()-1] = '{s: -16'sd1, c: 1'b0};
    wait_output(lat);
    consume("floor");
  endtask

  task automatic test_backpressure();
    int   lat;
    exp_t e;
    send_frame(pack_s(16'sd1000, 16'sd2000, 16'sd3000, 16'sd4000), pack_v(128, 128, 128, 128), 4'b0000);
    wait_output(lat);
    e = sb[0];
    for (int i = 0; i < 10; i++) begin
      samples  = {$urandom, $urandom};
      volumes  = $urandom;
      in_valid = i[0];
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sample !== e.s || clip !== e.c) begin
        errors++;
        $display("FAIL backpressure_hold cyc=%0d valid=%0b ready=%0b sample=%0d clip=%0b expected 1/0/%0d/%0b",
                 i, out_valid, in_ready, out_sample, clip, e.s, e.c);
      end
    end
    in_valid = 1'b0;
    consume("backpressure");
    repeat (NUM_CH + 4) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_ignored_frame out_valid=%0b expected 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_accum();
    int   lat;
    logic seen;
    send_frame(pack_s(16'sd9000, 16'sd9000, 16'sd9000, 16'sd9000), pack_v(200, 200, 200, 200), 4'b0000);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid in_ready got %0b expected 0", in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_sample !== 16'sd0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_state valid=%0b sample=%0d ready=%0b expected 0/0/0", out_valid, out_sample, in_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    void'(sb.pop_back());
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_release in_ready got %0b expected 1", in_ready);
    end
    seen = 1'b0;
    repeat (NUM_CH + 4) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_aborted out_valid seen=%0b expected 0", seen);
    end
    send_frame(pack_s(16'sd400, 16'sd400, 16'sd400, 16'sd400), pack_v(128, 128, 128, 128), 4'b0000);
    sb[sb.size()-1] = '{s: 16'sd400, c: 1'b0};
    wait_output(lat);
    consume("after_reset");
  endtask

  task automatic test_back_to_back();
    int lat;
    for (int i = 0; i < 8; i++) begin
      send_frame({$urandom, $urandom}, $urandom, 4'($urandom));
      wait_output(lat);
      checks++;
      if (lat != NUM_CH + 1) begin
        errors++;
        $display("FAIL b2b_latency frame=%0d got %0d expected %0d", i, lat, NUM_CH + 1);
      end
      consume("b2b");
    end
  endtask

  initial begin
    test_reset();
    test_unity();
    test_saturation();
    test_mute_floor();
    test_backpressure();
    test_reset_mid_accum();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
